// File: rtl/prio_code_decoder_pkg.sv
// Shared definitions for the prioritised code-to-line decoder: FSM state
// encoding, bus widths, the idle line pattern and counter load helper.
package prio_code_decoder_pkg;

    localparam int          CODE_W = 3;
    localparam int          LINE_W = 8;
    localparam int          CNT_W  = 8;
    localparam logic [7:0]  Y_IDLE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Counters hold "cycles remaining after this one", so a phase of N
    // cycles is loaded with N-1 and ends when the counter reads zero.
    function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/dec3to8_n.sv
// Combinational 3-to-8 active-low decoder with enable. When disabled every
// line is released (high). The parent registers the result.
module dec3to8_n
    import prio_code_decoder_pkg::*;
(
    input  logic              i_en,
    input  logic [CODE_W-1:0] i_code,
    output logic [LINE_W-1:0] o_y_n
);

    // One-cold decode of the code when enabled, all lines high otherwise
    always_comb begin
        o_y_n = Y_IDLE;
        if (i_en) begin
            o_y_n = ~(8'h01 << i_code);
        end else begin
            o_y_n = Y_IDLE;
        end
    end

endmodule

// File: rtl/prio_code_decoder.sv
// Request-driven line decoder. Each accepted code drives one active-low line
// for HOLD_CYCLES, then releases all lines for GAP_CYCLES. A one-deep pending
// buffer absorbs a request arriving while a burst is in progress so that no
// request is ever dropped. en_n high aborts everything at the next edge.
module prio_code_decoder
    import prio_code_decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_n,
    input  logic [CODE_W-1:0] a,
    input  logic              gs_n,
    output logic              ready,
    output logic [LINE_W-1:0] y_n,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = cnt_load(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LOAD  = cnt_load(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CODE_W-1:0]   r_code;
    logic [CODE_W-1:0]   w_code_nxt;
    logic [CODE_W-1:0]   r_pend_code;
    logic [CODE_W-1:0]   w_pend_code_nxt;
    logic                r_pend_valid;
    logic                w_pend_valid_nxt;
    logic                w_ready;
    logic                w_xfer;
    logic                w_dec_en;
    logic [LINE_W-1:0]   w_y_n_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic [LINE_W-1:0]   r_y_n;
    logic                r_busy;
    logic                r_done;

    // Acceptance window: never in reset or while disabled; in a burst only
    // when the pending slot is free
    always_comb begin
        w_ready = 1'b0;
        if (!rst_n || en_n) begin
            w_ready = 1'b0;
        end else if (r_state == IDLE) begin
            w_ready = 1'b1;
        end else begin
            w_ready = ~r_pend_valid;
        end
    end

    assign w_xfer = w_ready & ~gs_n;
    assign ready  = w_ready;

    // State, counter, active code and pending buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_code       <= '0;
            r_pend_code  <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_code       <= w_code_nxt;
            r_pend_code  <= w_pend_code_nxt;
            r_pend_valid <= w_pend_valid_nxt;
        end
    end

    // Next-state logic: phase sequencing, pending fill/drain and abort
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_code_nxt       = r_code;
        w_pend_code_nxt  = r_pend_code;
        w_pend_valid_nxt = r_pend_valid;
        if (en_n) begin
            w_state_nxt      = IDLE;
            w_cnt_nxt        = '0;
            w_pend_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        w_state_nxt = DRIVE;
                        w_code_nxt  = a;
                        w_cnt_nxt   = HOLD_LOAD;
                    end else begin
                        w_cnt_nxt   = '0;
                    end
                end
                DRIVE: begin
                    if (w_xfer) begin
                        w_pend_code_nxt  = a;
                        w_pend_valid_nxt = 1'b1;
                    end else begin
                        w_pend_valid_nxt = r_pend_valid;
                    end
                    if (r_cnt == '0) begin
                        w_state_nxt = GAP;
                        w_cnt_nxt   = GAP_LOAD;
                    end else begin
                        w_cnt_nxt   = r_cnt - CNT_ONE;
                    end
                end
                GAP: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                        if (w_xfer) begin
                            w_pend_code_nxt  = a;
                            w_pend_valid_nxt = 1'b1;
                        end else begin
                            w_pend_valid_nxt = r_pend_valid;
                        end
                    end else if (r_pend_valid) begin
                        // Buffered request takes priority; ready is low here
                        w_state_nxt      = DRIVE;
                        w_code_nxt       = r_pend_code;
                        w_pend_valid_nxt = 1'b0;
                        w_cnt_nxt        = HOLD_LOAD;
                    end else if (w_xfer) begin
                        // Last gap cycle with empty buffer: bypass straight in
                        w_state_nxt = DRIVE;
                        w_code_nxt  = a;
                        w_cnt_nxt   = HOLD_LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt      = IDLE;
                    w_cnt_nxt        = '0;
                    w_pend_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs line up
    // with the state they describe
    always_comb begin
        w_dec_en   = 1'b0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            IDLE: begin
                w_dec_en   = 1'b0;
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
            DRIVE: begin
                w_dec_en   = 1'b1;
                w_busy_nxt = 1'b1;
                w_done_nxt = (w_cnt_nxt == '0);
            end
            GAP: begin
                w_dec_en   = 1'b0;
                w_busy_nxt = 1'b1;
                w_done_nxt = 1'b0;
            end
            default: begin
                w_dec_en   = 1'b0;
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    dec3to8_n u_dec (
        .i_en   (w_dec_en),
        .i_code (w_code_nxt),
        .o_y_n  (w_y_n_nxt)
    );

    // Glitch-free output registers; reset releases the lines asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_n  <= Y_IDLE;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_y_n  <= w_y_n_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign y_n  = r_y_n;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_prio_code_decoder.sv
// Scenario bench for prio_code_decoder with default parameters
// (HOLD_CYCLES=4, GAP_CYCLES=1). Each scenario queues per-cycle stimulus and
// the outputs expected after the following rising edge, then replays them.
module tb_prio_code_decoder;

    logic       clk;
    logic       rst_n;
    logic       en_n;
    logic [2:0] a;
    logic       gs_n;
    logic       ready;
    logic [7:0] y_n;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic       en_n;
        logic       gs_n;
        logic [2:0] a;
    } stim_t;

    typedef struct packed {
        logic [7:0] y;
        logic       busy;
        logic       done;
        logic       rdy;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    prio_code_decoder #(
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en_n  (en_n),
        .a     (a),
        .gs_n  (gs_n),
        .ready (ready),
        .y_n   (y_n),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_stim(input logic en, input logic gs, input logic [2:0] aa, input int n);
        for (int i = 0; i < n; i++) stim_q.push_back('{en_n: en, gs_n: gs, a: aa});
    endtask

    task automatic push_exp(input logic [7:0] y, input logic b, input logic d, input logic r, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{y: y, busy: b, done: d, rdy: r});
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en_n = 1'b0; gs_n = 1'b0; a = 3'd4;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({y_n, busy, done, ready} !== {8'hFF, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got y_n=%h busy=%b done=%b ready=%b want FF 0 0 0", y_n, busy, done, ready);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready got %b want 1", ready);
        end
        gs_n = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({y_n, busy, done} !== {8'hFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_idle got y_n=%h busy=%b done=%b want FF 0 0", y_n, busy, done);
        end
    endtask

    task automatic test_single();
        stim_t s; exp_t e; int cyc = 0;
        push_stim(1'b0, 1'b0, 3'd5, 1); push_stim(1'b0, 1'b1, 3'd0, 6);
        push_exp(8'hDF, 1'b1, 1'b0, 1'b1, 3); push_exp(8'hDF, 1'b1, 1'b1, 1'b1, 1);
        push_exp(8'hFF, 1'b1, 1'b0, 1'b1, 1); push_exp(8'hFF, 1'b0, 1'b0, 1'b1, 2);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); en_n = s.en_n; gs_n = s.gs_n; a = s.a;
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); cyc++; n_checks++;
            if ({y_n, busy, done, ready} !== e) begin
                n_fail++;
                $display("FAIL single cyc=%0d got y_n=%h busy=%b done=%b ready=%b want %h %b %b %b",
                         cyc, y_n, busy, done, ready, e.y, e.busy, e.done, e.rdy);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s; exp_t e; int cyc = 0;
        push_stim(1'b0, 1'b0, 3'd2, 1); push_stim(1'b0, 1'b0, 3'd6, 1); push_stim(1'b0, 1'b1, 3'd0, 9);
        push_exp(8'hFB, 1'b1, 1'b0, 1'b1, 1); push_exp(8'hFB, 1'b1, 1'b0, 1'b0, 2);
        push_exp(8'hFB, 1'b1, 1'b1, 1'b0, 1); push_exp(8'hFF, 1'b1, 1'b0, 1'b0, 1);
        push_exp(8'hBF, 1'b1, 1'b0, 1'b1, 3); push_exp(8'hBF, 1'b1, 1'b1, 1'b1, 1);
        push_exp(8'hFF, 1'b1, 1'b0, 1'b1, 1); push_exp(8'hFF, 1'b0, 1'b0, 1'b1, 1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); en_n = s.en_n; gs_n = s.gs_n; a = s.a;
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); cyc++; n_checks++;
            if ({y_n, busy, done, ready} !== e) begin
                n_fail++;
                $display("FAIL back_to_back cyc=%0d got y_n=%h busy=%b done=%b ready=%b want %h %b %b %b",
                         cyc, y_n, busy, done, ready, e.y, e.busy, e.done, e.rdy);
            end
        end
    endtask

    task automatic test_held_request();
        stim_t s; exp_t e; int cyc = 0;
        push_stim(1'b0, 1'b0, 3'd3, 12); push_stim(1'b0, 1'b1, 3'd0, 9);
        for (int b = 0; b < 3; b++) begin
            push_exp(8'hF7, 1'b1, 1'b0, 1'b1, 1); push_exp(8'hF7, 1'b1, 1'b0, 1'b0, 2);
            push_exp(8'hF7, 1'b1, 1'b1, 1'b0, 1); push_exp(8'hFF, 1'b1, 1'b0, 1'b0, 1);
        end
        push_exp(8'hF7, 1'b1, 1'b0, 1'b1, 3); push_exp(8'hF7, 1'b1, 1'b1, 1'b1, 1);
        push_exp(8'hFF, 1'b1, 1'b0, 1'b1, 1); push_exp(8'hFF, 1'b0, 1'b0, 1'b1, 1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); en_n = s.en_n; gs_n = s.gs_n; a = s.a;
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); cyc++; n_checks++;
            if ({y_n, busy, done, ready} !== e) begin
                n_fail++;
                $display("FAIL held_request cyc=%0d got y_n=%h busy=%b done=%b ready=%b want %h %b %b %b",
                         cyc, y_n, busy, done, ready, e.y, e.busy, e.done, e.rdy);
            end
        end
    endtask

    task automatic test_last_gap_bypass();
        stim_t s; exp_t e; int cyc = 0;
        push_stim(1'b0, 1'b0, 3'd5, 1); push_stim(1'b0, 1'b1, 3'd0, 4);
        push_stim(1'b0, 1'b0, 3'd0, 1); push_stim(1'b0, 1'b1, 3'd0, 5);
        push_exp(8'hDF, 1'b1, 1'b0, 1'b1, 3); push_exp(8'hDF, 1'b1, 1'b1, 1'b1, 1);
        push_exp(8'hFF, 1'b1, 1'b0, 1'b1, 1);
        push_exp(8'hFE, 1'b1, 1'b0, 1'b1, 3); push_exp(8'hFE, 1'b1, 1'b1, 1'b1, 1);
        push_exp(8'hFF, 1'b1, 1'b0, 1'b1, 1); push_exp(8'hFF, 1'b0, 1'b0, 1'b1, 1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); en_n = s.en_n; gs_n = s.gs_n; a = s.a;
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); cyc++; n_checks++;
            if ({y_n, busy, done, ready} !== e) begin
                n_fail++;
                $display("FAIL last_gap_bypass cyc=%0d got y_n=%h busy=%b done=%b ready=%b want %h %b %b %b",
                         cyc, y_n, busy, done, ready, e.y, e.busy, e.done, e.rdy);
            end
        end
    endtask

    task automatic test_enable_abort();
        stim_t s; exp_t e; int cyc = 0;
        push_stim(1'b0, 1'b0, 3'd7, 1); push_stim(1'b0, 1'b0, 3'd4, 1);
        push_stim(1'b1, 1'b0, 3'd5, 1); push_stim(1'b0, 1'b1, 3'd0, 4);
        push_exp(8'h7F, 1'b1, 1'b0, 1'b1, 1); push_exp(8'h7F, 1'b1, 1'b0, 1'b0, 1);
        push_exp(8'hFF, 1'b0, 1'b0, 1'b0, 1); push_exp(8'hFF, 1'b0, 1'b0, 1'b1, 4);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); en_n = s.en_n; gs_n = s.gs_n; a = s.a;
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); cyc++; n_checks++;
            if ({y_n, busy, done, ready} !== e) begin
                n_fail++;
                $display("FAIL enable_abort cyc=%0d got y_n=%h busy=%b done=%b ready=%b want %h %b %b %b",
                         cyc, y_n, busy, done, ready, e.y, e.busy, e.done, e.rdy);
            end
        end
    endtask

    task automatic test_reset_mid_drive();
        stim_t s; exp_t e; int cyc = 0;
        en_n = 1'b0; gs_n = 1'b0; a = 3'd6;
        @(posedge clk); @(negedge clk);
        gs_n = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({y_n, busy} !== {8'hBF, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_reset_pre got y_n=%h busy=%b want BF 1", y_n, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({y_n, busy, done, ready} !== {8'hFF, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_async got y_n=%h busy=%b done=%b ready=%b want FF 0 0 0", y_n, busy, done, ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_stim(1'b0, 1'b0, 3'd1, 1); push_stim(1'b0, 1'b1, 3'd0, 5);
        push_exp(8'hFD, 1'b1, 1'b0, 1'b1, 3); push_exp(8'hFD, 1'b1, 1'b1, 1'b1, 1);
        push_exp(8'hFF, 1'b1, 1'b0, 1'b1, 1); push_exp(8'hFF, 1'b0, 1'b0, 1'b1, 1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); en_n = s.en_n; gs_n = s.gs_n; a = s.a;
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); cyc++; n_checks++;
            if ({y_n, busy, done, ready} !== e) begin
                n_fail++;
                $display("FAIL mid_reset_after cyc=%0d got y_n=%h busy=%b done=%b ready=%b want %h %b %b %b",
                         cyc, y_n, busy, done, ready, e.y, e.busy, e.done, e.rdy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_held_request();
        test_last_gap_bypass();
        test_enable_abort();
        test_reset_mid_drive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/prio_code_decoder.md
PRIO_CODE_DECODER -- requirements
Module: prio_code_decoder

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: cycles an output line is held low per request; legal range 1..255.
REQ-002 SHALL have parameter GAP_CYCLES, default 1: all-high cycles between consecutive requests; legal range 1..255.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port en_n, input, 1, active-low enable.
REQ-007 SHALL have port a, input, 3, binary index of the requested line (7 = line 7).
REQ-008 SHALL have port gs_n, input, 1, active-low request valid.
REQ-009 SHALL have port ready, output, 1, high when a request can be accepted this cycle.
REQ-010 SHALL have port y_n, output, 8, active-low decoded lines, at most one low.
REQ-011 SHALL have port busy, output, 1, high in the DRIVE or GAP state.
REQ-012 SHALL have port done, output, 1, one-cycle pulse on the last DRIVE cycle.

Function
REQ-013 Transfer SHALL occur in a cycle with en_n=0, gs_n=0 and ready=1; a held-low gs_n SHALL give one transfer per cycle while ready=1.
REQ-014 FSM states SHALL be IDLE, DRIVE and GAP, plus a one-deep pending buffer (code and valid flag).
REQ-015 ready SHALL be 1 in IDLE, and in DRIVE or GAP only when the pending buffer is empty; ready SHALL be 0 when en_n=1.
REQ-016 IDLE with a transfer SHALL load a into the output code, go to DRIVE, and drive y_n[a]=0 from the next edge; latency is 1 cycle.
REQ-017 DRIVE SHALL hold exactly one y_n bit low for exactly HOLD_CYCLES cycles, with done=1 in the last of them, then go to GAP.
REQ-018 GAP SHALL hold y_n=8'hFF for exactly GAP_CYCLES cycles.
REQ-019 At the end of GAP, a valid pending buffer SHALL load into DRIVE and empty.
REQ-020 At the end of GAP with the buffer empty and a transfer in that same cycle, the request SHALL go directly to DRIVE without passing through the buffer.
REQ-021 At the end of GAP with no request, the FSM SHALL return to IDLE.
REQ-022 A transfer during DRIVE or GAP, other than the last GAP cycle, SHALL fill the pending buffer; no request SHALL ever be dropped or overwritten.
REQ-023 en_n=1 at any time SHALL, at the next edge, abort the operation: y_n=8'hFF, pending cleared, state IDLE, done=0.
REQ-024 y_n, busy and done SHALL be driven only from registers (glitch-free).
REQ-025 Hold and gap counters SHALL be 8 bits wide, count down, and never wrap.

Reset
REQ-026 While rst_n=0, outputs SHALL be: y_n=8'hFF, busy=0, done=0, ready=0, state IDLE, pending empty, counters 0.
REQ-027 Reset asserted mid-DRIVE SHALL release the low line immediately, without waiting for a clock edge.
REQ-028 ready=1 SHALL first be possible in the first cycle after rst_n deasserts.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE, DRIVE, GAP) and the constants Y_IDLE=8'hFF and CODE_W=3.
REQ-030 The block SHALL contain one sub-module, dec3to8_n: a combinational 3-to-8 active-low decoder with enable, registered by the parent.

Verification
REQ-031 Single request: a=5, gs_n=0 for 1 cycle, defaults -> y_n=8'hDF for 4 cycles, done on the 4th, then FF for 1 cycle, busy low after.
REQ-032 Back-to-back: a=2 then a=6 one cycle later -> y_n=FB x4, FF x1, BF x4; ready=0 while a=6 is pending.
REQ-033 Held gs_n=0, a=3 for 12 cycles -> repeated F7 x4 / FF x1 bursts; no cycle with more than one low bit.
REQ-034 Last-GAP-cycle transfer: a=0 on the final gap cycle, buffer empty -> y_n=FE on the very next edge.
REQ-035 en_n pulsed high mid-DRIVE on a=7 -> y_n=FF next edge, pending lost, ready=0 while en_n=1.
REQ-036 rst_n low mid-DRIVE -> y_n=FF asynchronously; after release a=1 request -> FD x4.
